// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the RV32E instruction fetch unit.
//   fetch_state_t : fetch sequencer states (IDLE/REQ/WAIT/HOLD)
//   INST_BYTES    : size of one instruction, the sequential pc step
//   RESET_PC      : default first fetch address after reset
//   word_align()  : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;

  // Instructions are word aligned; low address bits are forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_pc_sel.sv
// ---------------------------------------------------------------------------
// ifu_pc_sel
// Combinational next-pc selection for the fetch unit.
// Priority: redirect > sequential increment > hold.
// Ports:
//   pc               in  32  current pc
//   state            in  2   current fetch state (fetch_state_t encoding)
//   inst_ready       in  1   decoder consumes the presented instruction
//   redirect_valid   in  1   redirect request from execute
//   redirect_pc_word in  30  redirect target, word address bits [31:2]
//   next_pc          out 32  pc value for the next cycle
// ---------------------------------------------------------------------------
module ifu_pc_sel
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  state,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc_word,
  output logic [31:0] next_pc
);

  fetch_state_t cur_state;
  logic         redirect_take;
  logic         inst_fire;

  assign cur_state = fetch_state_t'(state);

  // Redirects arriving before the first fetch has started are ignored.
  assign redirect_take = redirect_valid && (cur_state != IDLE);

  // Only a consumed instruction advances the pc.
  assign inst_fire = (cur_state == HOLD) && inst_ready;

  always_comb begin
    next_pc = pc;
    if (redirect_take) begin
      next_pc = {redirect_pc_word, 2'b00};
    end else if (inst_fire) begin
      // Wraps silently past 32'hFFFF_FFFC.
      next_pc = pc + 32'(INST_BYTES);
    end
  end

endmodule

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu
// Instruction fetch unit for the RV32E single-issue core. Holds the pc,
// issues one instruction-memory read at a time and presents the fetched word
// and its pc to the decoder over valid/ready. Execute-stage redirects replace
// the pc; a fetch already in flight when a redirect arrives is discarded.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req_valid   out 1   read request valid (state REQ)
//   imem_req_ready   in  1   memory accepts the request
//   imem_addr        out 32  request address (current pc)
//   imem_rsp_valid   in  1   read data valid, one pulse per accepted request
//   imem_rsp_data    in  32  read data
//   inst_valid       out 1   instruction valid toward the decoder (state HOLD)
//   inst_ready       in  1   decoder consumes the instruction
//   inst             out 32  fetched instruction
//   inst_pc          out 32  address of inst
//   redirect_valid   in  1   one-cycle pc redirect
//   redirect_pc      in  32  redirect target
//   misalign         out 1   one-cycle pulse: last redirect target was not
//                            word aligned
// All outputs come straight from registers; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module ifu #(
  parameter logic [31:0] RESET_PC = ifu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign
);

  import ifu_pkg::*;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  inst_reg, inst_next;
  logic [31:0]  inst_pc_reg, inst_pc_next;
  logic         discard_reg, discard_next;
  logic         misalign_reg, misalign_next;
  logic         redirect_take;

  // -------------------------------------------------------------------------
  // Next pc
  // -------------------------------------------------------------------------
  ifu_pc_sel u_pc_sel (
    .pc               (pc_reg),
    .state            (state_reg),
    .inst_ready       (inst_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc_word (redirect_pc[31:2]),
    .next_pc          (pc_next)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      inst_reg     <= 32'h0;
      inst_pc_reg  <= RESET_PC;
      discard_reg  <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inst_reg     <= inst_next;
      inst_pc_reg  <= inst_pc_next;
      discard_reg  <= discard_next;
      misalign_reg <= misalign_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  assign redirect_take = redirect_valid && (state_reg != IDLE);

  always_comb begin
    state_next    = state_reg;
    discard_next  = discard_reg;
    inst_next     = inst_reg;
    inst_pc_next  = inst_pc_reg;
    misalign_next = redirect_take && (redirect_pc[1:0] != 2'b00);

    unique case (state_reg)
      IDLE: begin
        state_next = REQ;
      end

      REQ: begin
        if (imem_req_ready) begin
          state_next = WAIT;
          // The accepted address is the pre-redirect pc, so its data is stale.
          discard_next = redirect_take;
        end
      end

      WAIT: begin
        if (imem_rsp_valid) begin
          if (discard_reg || redirect_take) begin
            // Stale response: drop it and refetch from the (new) pc.
            state_next   = REQ;
            discard_next = 1'b0;
          end else begin
            // pc cannot change while waiting without a redirect, so pc_reg
            // is still the address of this response.
            inst_next    = imem_rsp_data;
            inst_pc_next = pc_reg;
            state_next   = HOLD;
          end
        end else if (redirect_take) begin
          discard_next = 1'b1;
        end
      end

      HOLD: begin
        // Redirect and consume both leave for REQ; the pc choice between
        // target and pc+4 is made in ifu_pc_sel.
        if (redirect_take || inst_ready) begin
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // -------------------------------------------------------------------------
  assign imem_req_valid = (state_reg == REQ);
  assign imem_addr      = pc_reg;
  assign inst_valid     = (state_reg == HOLD);
  assign inst           = inst_reg;
  assign inst_pc        = inst_pc_reg;
  assign misalign       = misalign_reg;

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu
// Directed scenarios followed by randomized traffic. The reference model is
// an architectural pc: it moves to the aligned redirect target on a redirect,
// otherwise advances by 4 whenever the decoder consumes an instruction. Every
// accepted memory request must use that pc, and every consumed instruction
// must carry that pc and the memory word stored there.
// ---------------------------------------------------------------------------
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        misalign;

  localparam logic [31:0] RPC = ifu_pkg::RESET_PC;

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_retired = 0;

  // Reference model / memory model state
  logic [31:0] model_pc  = RPC;
  logic        exp_mis   = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] held_inst = 32'h0;
  logic [31:0] held_pc   = 32'h0;
  int          rsp_timer = -1;
  logic [31:0] rsp_addr  = 32'h0;
  int          mem_delay = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RPC) return 32'h0010_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick(input logic rr, input logic ir, input logic rv, input logic [31:0] rpc);
    // Properties of the current outputs
    chk1("misalign", misalign, exp_mis);
    chk1("one_outstanding", imem_req_valid && (rsp_timer >= 0), 1'b0);
    if (prev_hold) begin
      chk1("hold_valid", inst_valid, 1'b1);
      chk32("hold_inst", inst, held_inst);
      chk32("hold_pc", inst_pc, held_pc);
    end
    // Memory response for the outstanding request
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (rsp_timer == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(rsp_addr);
      rsp_timer      = -1;
    end else if (rsp_timer > 0) begin
      rsp_timer--;
    end
    // Inputs for the coming rising edge
    imem_req_ready = rr;
    inst_ready     = ir;
    redirect_valid = rv;
    redirect_pc    = rpc;
    // Reference model
    if (imem_req_valid && rr) begin
      chk32("req_addr", imem_addr, model_pc);
      rsp_addr  = imem_addr;
      rsp_timer = mem_delay - 1;
    end
    prev_hold = inst_valid && !ir && !rv;
    held_inst = inst;
    held_pc   = inst_pc;
    if (inst_valid && ir && !rv) begin
      chk32("inst_pc", inst_pc, model_pc);
      chk32("inst_data", inst, mem_word(model_pc));
      $display("retire pc=%h inst=%h", inst_pc, inst);
      model_pc = model_pc + 32'd4;
      n_retired++;
    end
    if (rv) model_pc = {rpc[31:2], 2'b00};
    exp_mis = rv && (rpc[1:0] != 2'b00);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    rsp_timer      = -1;
    model_pc       = RPC;
    exp_mis        = 1'b0;
    prev_hold      = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_misalign", misalign, 1'b0);
    chk32("rst_inst", inst, 32'h0);
    chk32("rst_inst_pc", inst_pc, RPC);
    chk32("rst_addr", imem_addr, RPC);
    rst = 1'b0;
    $display("reset released");
  endtask

  initial begin
    logic        rv;
    logic [31:0] rpc;
    logic        after_rst;

    // Reset and the first zero-wait fetch
    do_reset();
    tick(0, 0, 0, 0);
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk32("first_addr", imem_addr, RPC);
    tick(1, 0, 0, 0);
    chk1("wait_inst_valid", inst_valid, 1'b0);
    tick(0, 0, 0, 0);
    chk1("first_inst_valid", inst_valid, 1'b1);
    chk32("first_inst", inst, 32'h0010_0093);
    chk32("first_inst_pc", inst_pc, RPC);

    // Decoder stall for 5 cycles
    repeat (5) begin
      tick(1, 0, 0, 0);
      chk1("stall_no_req", imem_req_valid, 1'b0);
      chk1("stall_valid", inst_valid, 1'b1);
      chk32("stall_inst", inst, 32'h0010_0093);
    end
    tick(0, 1, 0, 0);
    chk32("seq_addr", imem_addr, 32'h8000_0004);
    chk1("seq_req_valid", imem_req_valid, 1'b1);

    // Redirect while waiting on a slow response
    mem_delay = 2;
    tick(1, 0, 0, 0);
    mem_delay = 1;
    tick(0, 0, 1, 32'h8000_0100);
    tick(0, 0, 0, 0);
    chk1("wait_redir_drop", inst_valid, 1'b0);
    chk32("wait_redir_addr", imem_addr, 32'h8000_0100);
    chk1("wait_redir_req", imem_req_valid, 1'b1);

    // Redirect together with inst_ready in HOLD
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk32("hold_fetch_pc", inst_pc, 32'h8000_0100);
    tick(0, 1, 1, 32'h8000_0040);
    chk1("hold_redir_valid", inst_valid, 1'b0);
    chk32("hold_redir_addr", imem_addr, 32'h8000_0040);

    // Misaligned redirect target
    tick(0, 0, 1, 32'h8000_0022);
    chk1("misalign_pulse", misalign, 1'b1);
    chk32("misalign_addr", imem_addr, 32'h8000_0020);
    tick(0, 0, 0, 0);
    chk1("misalign_end", misalign, 1'b0);

    // Redirect in the same cycle as a request handshake
    tick(1, 0, 1, 32'h8000_0200);
    tick(0, 0, 0, 0);
    chk1("req_redir_drop", inst_valid, 1'b0);
    chk32("req_redir_addr", imem_addr, 32'h8000_0200);

    // pc wrap
    tick(0, 0, 1, 32'hFFFF_FFFC);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk32("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    tick(0, 1, 0, 0);
    chk32("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset while a response is outstanding
    mem_delay = 3;
    tick(1, 0, 0, 0);
    mem_delay = 1;
    do_reset();
    tick(0, 0, 0, 0);
    chk32("post_rst_addr", imem_addr, RPC);
    chk1("post_rst_req", imem_req_valid, 1'b1);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk32("post_rst_inst", inst, 32'h0010_0093);

    // Randomized traffic
    after_rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        after_rst = 1'b1;
      end
      mem_delay = $urandom_range(1, 3);
      rv  = ($urandom_range(0, 15) == 0) && !after_rst;
      rpc = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (RPC | (32'($urandom) & 32'h0000_0FFF));
      tick(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, rv, rpc);
      after_rst = 1'b0;
    end
    chk1("progress", n_retired > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the RV32E single-issue core: holds the PC, issues one instruction-memory read at a time, and presents the fetched word plus its PC to the decoder over a valid/ready handshake. It sits between the instruction memory port and the IDU. It accepts PC redirects from the execute stage (branch/jump) and discards any fetch made stale by a redirect.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  request address, equals internal PC while imem_req_valid=1
- imem_rsp_valid  in  1  read data valid, one pulse per accepted request
- imem_rsp_data  in  32  read data
- inst_valid  out  1  inst/inst_pc valid toward the decoder
- inst_ready  in  1  decoder consumes inst this cycle
- inst  out  32  fetched instruction
- inst_pc  out  32  address of inst
- redirect_valid  in  1  one-cycle PC redirect from execute
- redirect_pc  in  32  redirect target
- misalign  out  1  registered one-cycle pulse: last redirect_pc had bits [1:0] != 0

## Operation
- States: IDLE, REQ, WAIT, HOLD. At most one memory request is outstanding.
- IDLE: entered only by reset. Moves to REQ on the first clock edge after rst deasserts.
- REQ: imem_req_valid=1 and imem_addr=pc. When imem_req_ready=1, moves to WAIT.
- WAIT: waits for imem_rsp_valid.
  - If the discard flag is clear: latch inst=imem_rsp_data and inst_pc=pc, then move to HOLD.
  - If the discard flag is set: drop the data, clear the flag, and move to REQ.
- HOLD: inst_valid=1. When inst_ready=1: pc<=pc+4 (modulo 2^32, wraps silently) and move to REQ.
- Redirect handling: on redirect_valid=1, pc<={redirect_pc[31:2],2'b00}. misalign is pulsed the next cycle if redirect_pc[1:0]!=0.
  - In REQ without a handshake that cycle: stay in REQ. The next request uses the new pc.
  - In REQ with a handshake that same cycle: the accepted address was the old pc. Move to WAIT with the discard flag set.
  - In WAIT: set the discard flag. If imem_rsp_valid arrives the same cycle, drop the data and move directly to REQ.
  - In HOLD: drop the held inst, deassert inst_valid the next cycle, and move to REQ. Redirect takes priority over a simultaneous inst_ready; pc is not incremented.
  - In IDLE: ignored.
- A redirect always wins over the pc+4 increment.
- Reset mid-operation: the state returns to IDLE immediately and any in-flight response is ignored. The memory must not return a response for a request accepted before reset.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, inst=32'h0, inst_pc=RESET_PC, inst_valid=0, imem_req_valid=0, discard=0, misalign=0.
- imem_req_valid, inst_valid, and imem_addr are decoded from registered state and pc only. There is no combinational path from any input to any output.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with a zero-wait-state memory, where imem_rsp_valid arrives the cycle after the handshake.
- inst and inst_pc are stable while inst_valid=1 and inst_ready=0.
- Redirect latency: the request for the target is issued 1 cycle after redirect_valid, or 1 cycle after the stale response if one is outstanding.
- imem_rsp_valid while in IDLE, REQ, or HOLD is a protocol violation and is ignored.

## Structure
- The shared core package holds:
  - the fetch state enum (IDLE/REQ/WAIT/HOLD);
  - INST_BYTES=4;
  - the RESET_PC default constant, which is also used by the testbench.
- One combinational sub-module, ifu_pc_sel, computes next-pc. Inputs: pc, state, handshake terms, redirect_valid, redirect_pc. Output: next pc. Priority: redirect > increment > hold. The rest lives in ifu.

## Test plan
- Reset, then a memory with ready=1 and rsp one cycle later returning 32'h0010_0093 -> first imem_addr=32'h8000_0000; inst=32'h0010_0093 with inst_pc=32'h8000_0000 on cycle 3; next imem_addr=32'h8000_0004.
- Decoder holds inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable; no new imem_req_valid until inst_ready=1.
- Redirect to 32'h8000_0100 while in WAIT -> pending response dropped (inst_valid stays 0); next imem_addr=32'h8000_0100.
- Redirect and inst_ready in the same HOLD cycle with redirect_pc=32'h8000_0040 -> next imem_addr=32'h8000_0040, not pc+4.
- redirect_pc=32'h8000_0022 -> misalign pulses for exactly 1 cycle; next imem_addr=32'h8000_0020.
- pc=32'hFFFF_FFFC consumed -> next imem_addr=32'h0000_0000; rst asserted mid-WAIT -> imem_req_valid=0 and inst_valid=0 immediately, first fetch after release at RESET_PC.
